// File: rtl/lsu_mem_if.sv
// Load/store responder between the execute/memory stage and data memory.
// Takes one decoded memory instruction at a time and runs it as a single
// valid/grant/rvalid bus transaction. The pipeline is stalled while the access
// is in flight. Load data comes back lane-aligned and sign- or zero-extended.
module lsu_mem_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    input  logic [DATA_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    // One spare bit so the counter can step past the limit after a late grant.
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q;
    logic                  err_q, err_d;
    logic                  we_q, sign_q, byte_q, half_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]            be_q;

    logic                  in_byte, in_half, in_misaligned;
    logic                  accept, busy, timeout;
    logic [3:0]            in_be;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] load_fmt;

    // MemType 2'b11 falls through to word handling everywhere.
    assign in_byte       = (MemType_i == 2'b01);
    assign in_half       = (MemType_i == 2'b10);
    assign in_misaligned = in_half ? Addr_i[0] : (!in_byte && (Addr_i[1:0] != 2'b00));
    assign accept        = (state_q == StIdle) && req_i;
    assign busy          = (state_q == StReq) || (state_q == StWait);
    assign timeout       = (cnt_q >= CntLast);

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = WriteData_i;
        if (in_byte) begin
            in_be    = 4'b0001 << Addr_i[1:0];
            in_wdata = {4{WriteData_i[7:0]}};
        end else if (in_half) begin
            in_be    = 4'b0011 << {Addr_i[1], 1'b0};
            in_wdata = {2{WriteData_i[15:0]}};
        end
    end

    // Pick the addressed lane of the returned word and extend it
    always_comb begin
        lane_b = mem_rdata_i[7:0];
        case (addr_q[1:0])
            2'b01:   lane_b = mem_rdata_i[15:8];
            2'b10:   lane_b = mem_rdata_i[23:16];
            2'b11:   lane_b = mem_rdata_i[31:24];
            default: lane_b = mem_rdata_i[7:0];
        endcase
        lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        // sign_q = 0 means sign-extend
        if (byte_q) begin
            load_fmt = {{24{!sign_q && lane_b[7]}}, lane_b};
        end else if (half_q) begin
            load_fmt = {{16{!sign_q && lane_h[15]}}, lane_h};
        end else begin
            load_fmt = mem_rdata_i;
        end
    end

    // Transaction sequencing; progress on the bus takes priority over timeout
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = in_misaligned ? StResp : StReq;
                    err_d   = in_misaligned;
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? StResp : StWait;
                end else if (timeout) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    state_d = StResp;
                end else if (timeout) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, error flag and busy-cycle counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= busy ? cnt_q + 1'b1 : '0;
        end
    end

    // Request fields captured once at acceptance and held for the whole access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
        end else if (accept) begin
            we_q    <= MemWrite_i;
            sign_q  <= MemSign_i;
            byte_q  <= in_byte;
            half_q  <= in_half;
            addr_q  <= Addr_i;
            wdata_q <= in_wdata;
            be_q    <= in_be;
        end
    end

    // Load result; only a successful read return updates it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if ((state_q == StWait) && mem_rvalid_i) begin
            rdata_q <= load_fmt;
        end
    end

    // Reset forces stall low even while a new request is being offered.
    assign stall_o     = !rst_i && (busy || accept);
    assign done_o      = (state_q == StResp);
    assign err_o       = (state_q == StResp) && err_q;
    assign ReadData_o  = rdata_q;
    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if. The stimulus process issues requests and
// plays the memory; expected completions and bus beats are queued at issue
// time from a byte-level memory model. A separate monitor compares them.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_i, req_i, MemWrite_i, MemSign_i;
    logic [1:0]  MemType_i;
    logic [31:0] Addr_i, WriteData_i;
    logic        stall_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] ReadData_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    lsu_mem_if #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .MemWrite_i  (MemWrite_i),
        .MemType_i   (MemType_i),
        .MemSign_i   (MemSign_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .ReadData_o  (ReadData_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          run;   // stalled cycles before done (accept cycle + REQ/WAIT)
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_err    = 0;
    int          done_seen = 0;
    int          stall_run = 0;
    logic [7:0]  ref_mem[int unsigned];
    logic [31:0] bus_mem[int unsigned];
    logic [31:0] last_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = dflt({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return dflt(wa);
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        bus_mem[wa] = w;
        for (int k = 0; k < 4; k++) ref_mem[wa + k] = w[8*k +: 8];
    endtask

    // tmode: 0 normal, 1 grant never given, 2 grant but no read data
    task automatic run_txn(input logic we, input logic [1:0] typ, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int g, input int r, input int tmode);
        int          n, start, waited, tm;
        logic        mis;
        exp_t        e;
        bus_t        b;
        logic [31:0] val, mask, ba, word, wa;
        tm  = (we && tmode == 2) ? 1 : tmode;
        n   = (typ == 2'b01) ? 1 : (typ == 2'b10) ? 2 : 4;
        mis = (int'(addr[1:0]) % n) != 0;
        e.rd = last_rd;
        if (mis) begin
            e.err = 1'b1; e.run = 1;
        end else if (tm != 0) begin
            e.err = 1'b1; e.run = 17;
        end else if (we) begin
            for (int k = 0; k < n; k++) ref_mem[addr + k] = wd[8*k +: 8];
            e.err = 1'b0; e.run = g + 2;
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++) val = val | (32'(ref_byte(addr + k)) << (8 * k));
            if (n < 4) begin
                mask = (32'd1 << (8 * n)) - 32'd1;
                if (!sign && val[8*n-1]) val = val | ~mask;
            end
            last_rd = val;
            e.err = 1'b0; e.rd = val; e.run = g + r + 3;
        end
        if (!mis) begin
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = 4'b0000; b.wdata = 32'd0;
            for (int i = 0; i < 4; i++) begin
                ba = b.addr + i;
                b.be[i] = (ba >= addr) && (ba < addr + n);
                b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
            end
            bus_q.push_back(b);
        end
        exp_q.push_back(e);
        start = done_seen;
        @(posedge clk); #1;
        req_i = 1'b1; MemWrite_i = we; MemType_i = typ; MemSign_i = sign;
        Addr_i = addr; WriteData_i = wd;
        @(posedge clk); #1;
        // fields must have been captured; scramble the live inputs
        Addr_i = $urandom; WriteData_i = $urandom; MemType_i = 2'($urandom);
        MemSign_i = 1'($urandom); MemWrite_i = 1'($urandom);
        if (!mis && tm != 1) begin
            for (int k = 0; k < g; k++) begin
                mem_rvalid_i = 1'($urandom);  // stray rvalid before grant
                mem_rdata_i  = $urandom;
                @(posedge clk); #1;
            end
            mem_rvalid_i = 1'b0;
            mem_gnt_i = 1'b1;
            wa = mem_addr_o;
            word = bus_word(wa);
            if (mem_we_o) begin
                for (int i = 0; i < 4; i++) if (mem_be_o[i]) word[8*i +: 8] = mem_wdata_o[8*i +: 8];
                bus_mem[wa] = word;
            end
            @(posedge clk); #1;
            mem_gnt_i = 1'b0;
            if (!we && tm == 0) begin
                for (int k = 0; k < r; k++) begin @(posedge clk); #1; end
                mem_rvalid_i = 1'b1; mem_rdata_i = word;
                @(posedge clk); #1;
                mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            end
        end
        waited = 0;
        while (done_seen == start && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        req_i = 1'b0;
        if (done_seen == start) begin
            n_checks++; n_err++;
            $display("FAIL no_done: no completion within 60 cycles for addr %h", addr);
            exp_q.delete(); bus_q.delete();
        end else if (tm == 1 && !mis && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
        end
    endtask

    // Monitor: bus beats and completions against the queued expectations
    always @(negedge clk) begin
        if (rst_i) begin
            stall_run = 0;
        end else begin
            if (mem_req_o) begin
                if (bus_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_req: mem_req_o=1 addr=%h, required idle bus", mem_addr_o);
                end else begin
                    chk("bus_addr", mem_addr_o, bus_q[0].addr);
                    chk("bus_be", {28'd0, mem_be_o}, {28'd0, bus_q[0].be});
                    chk("bus_we", {31'd0, mem_we_o}, {31'd0, bus_q[0].we});
                    if (bus_q[0].we) chk("bus_wdata", mem_wdata_o, bus_q[0].wdata);
                    chk("stall_busy", {31'd0, stall_o}, 32'd1);
                    if (mem_gnt_i) void'(bus_q.pop_front());
                end
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_done: done_o=1, required no completion");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("err", {31'd0, err_o}, {31'd0, mon_e.err});
                    chk("read_data", ReadData_o, mon_e.rd);
                    chk("latency", stall_run, mon_e.run);
                    chk("stall_in_resp", {31'd0, stall_o}, 32'd0);
                    done_seen++;
                end
                stall_run = 0;
            end else if (stall_o) begin
                stall_run++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  typ;
        logic [31:0] a;
        int          tm;
        rst_i = 1'b1; req_i = 1'b0; MemWrite_i = 1'b0; MemType_i = 2'b00; MemSign_i = 1'b0;
        Addr_i = 32'd0; WriteData_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        last_rd = 32'd0;
        #12;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rdata", ReadData_o, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_be", {28'd0, mem_be_o}, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Directed cases
        preload(32'h100, 32'h80FF1234);
        run_txn(1'b0, 2'b01, 1'b1, 32'h103, $urandom, 0, 0, 0);
        chk("lbu_value", ReadData_o, 32'h00000080);
        preload(32'h200, 32'h80017FFF);
        run_txn(1'b0, 2'b10, 1'b0, 32'h202, $urandom, 0, 0, 0);
        chk("lh_value", ReadData_o, 32'hFFFF8001);
        run_txn(1'b0, 2'b10, 1'b1, 32'h202, $urandom, 1, 2, 0);
        chk("lhu_value", ReadData_o, 32'h00008001);
        run_txn(1'b1, 2'b01, 1'b0, 32'h41, 32'hDEADBEAA, 3, 0, 0);
        run_txn(1'b0, 2'b01, 1'b1, 32'h41, $urandom, 0, 0, 0);
        chk("sb_readback", ReadData_o, 32'h000000AA);
        run_txn(1'b1, 2'b00, 1'b0, 32'h106, $urandom, 0, 0, 0);
        chk("misaligned_keeps_rdata", ReadData_o, 32'h000000AA);
        preload(32'h300, 32'h12345678);
        run_txn(1'b0, 2'b00, 1'b0, 32'h300, $urandom, 0, 0, 2);
        chk("timeout_keeps_rdata", ReadData_o, 32'h000000AA);
        run_txn(1'b0, 2'b00, 1'b0, 32'h300, $urandom, 0, 0, 0);
        chk("lw_after_timeout", ReadData_o, 32'h12345678);

        // Reset in the middle of a load's WAIT phase
        bus_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'd0});
        @(posedge clk); #1;
        req_i = 1'b1; MemWrite_i = 1'b0; MemType_i = 2'b00; Addr_i = 32'h300;
        @(posedge clk); #1;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        @(posedge clk); #1;
        chk("wait_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1; req_i = 1'b0;
        #1;
        chk("rst_wait_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_wait_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wait_done", {31'd0, done_o}, 32'd0);
        chk("rst_wait_rdata", ReadData_o, 32'd0);
        exp_q.delete(); bus_q.delete(); last_rd = 32'd0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        chk("late_rvalid_ignored", ReadData_o, 32'd0);
        chk("late_rvalid_no_stall", {31'd0, stall_o}, 32'd0);
        run_txn(1'b0, 2'b00, 1'b0, 32'h100, $urandom, 0, 0, 0);
        chk("lw_after_reset", ReadData_o, 32'h80FF1234);

        // Randomized traffic over a small window so loads see earlier stores
        for (int t = 0; t < 250; t++) begin
            typ = 2'($urandom);
            a   = 32'h1000 + $urandom_range(0, 63);
            tm  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn(1'($urandom), typ, 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), tm);
        end
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
